// File: rtl/cpu_bus_master.sv
// NES CPU bus master: turns a req/ack handshake into M2-phased address/data cycles.
// Optional CPU_BUS_MASTER_IDLE_CYCLE_EN runs dummy reads while idle so M2 free-runs.
module cpu_bus_master #(
    parameter int unsigned T_LO = 3,
    parameter int unsigned T_HI = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [15:0] cpu_addr,
    output logic        cpu_rw,
    output logic        cpu_m2,
    output logic [7:0]  cpu_dout,
    output logic        cpu_doe,
    input  logic [7:0]  cpu_din
);

    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          dummy_q, dummy_d;
    logic          m2_q, m2_d;
    logic          doe_q, doe_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        dummy_d = dummy_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_ADDR;
                    cnt_d   = CW'(T_LO - 1);
                    addr_d  = req_addr;
                    rw_d    = req_rw;
                    dout_d  = req_wdata;
                    dummy_d = 1'b0;
                end
`ifdef CPU_BUS_MASTER_IDLE_CYCLE_EN
                else begin
                    // Dummy read at the last address keeps M2 running
                    state_d = S_ADDR;
                    cnt_d   = CW'(T_LO - 1);
                    rw_d    = 1'b1;
                    dummy_d = 1'b1;
                end
`endif
            end
            S_ADDR: begin
                if (cnt_q == CW'(0)) begin
                    state_d = S_DATA;
                    cnt_d   = CW'(T_HI - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(0)) begin
                    state_d = S_HOLD;
                    if (rw_q && !dummy_q) begin
                        rdata_d = cpu_din;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Phase outputs follow the state being entered so they stay registered
        m2_d   = (state_d == S_DATA);
        doe_d  = (state_d == S_DATA) && !rw_d;
        ack_d  = (state_d == S_HOLD) && !dummy_d;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            dout_q  <= '0;
            rdata_q <= '0;
            dummy_q <= 1'b0;
            m2_q    <= 1'b0;
            doe_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            dummy_q <= dummy_d;
            m2_q    <= m2_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign cpu_addr = addr_q;
    assign cpu_rw   = rw_q;
    assign cpu_m2   = m2_q;
    assign cpu_dout = dout_q;
    assign cpu_doe  = doe_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Scoreboard bench for cpu_bus_master (T_LO=T_HI=3); CPU_BUS_MASTER_IDLE_CYCLE_EN adds the dummy-cycle test.
module tb_cpu_bus_master;

    localparam int unsigned T_LO = 3;
    localparam int unsigned T_HI = 3;
    localparam int unsigned LAT  = T_LO + T_HI + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_rw = 1'b1;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  cpu_din = '0;
    logic        ack, busy, cpu_rw, cpu_m2, cpu_doe;
    logic [7:0]  rdata, cpu_dout;
    logic [15:0] cpu_addr;

    cpu_bus_master #(.T_LO(T_LO), .T_HI(T_HI)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .busy(busy), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_m2(cpu_m2),
        .cpu_dout(cpu_dout), .cpu_doe(cpu_doe), .cpu_din(cpu_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          acc;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  last_rd = '0;
    logic [15:0] model_addr = '0;
    bit          din_fix_en = 1'b0;
    logic [7:0]  din_fix = '0;
    int          last_acc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          m2_cnt = 0;
    int          doe_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] din_of(input int c);
        return 8'(c * 37 + 90);
    endfunction

    // Bus data changes every clock so each read proves its sampling edge
    always @(negedge clk) cpu_din = din_fix_en ? din_fix : din_of(cyc);

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0 && cyc >= sb[0].acc) begin
            check_eq("cpu_addr", 32'(cpu_addr), 32'(sb[0].addr));
            check_eq("cpu_rw", 32'(cpu_rw), 32'(sb[0].rw));
            if (cpu_m2) m2_cnt++;
            if (cpu_doe) begin
                doe_cnt++;
                check_eq("cpu_dout", 32'(cpu_dout), 32'(sb[0].wdata));
                check_eq("doe_in_m2", 32'(cpu_m2), 32'd1);
            end
        end
`ifndef CPU_BUS_MASTER_IDLE_CYCLE_EN
        if (!busy) check_eq("idle_m2", 32'(cpu_m2), 32'd0);
`endif
        if (ack) begin
            if (sb.size() == 0) begin
                check_eq("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("latency", 32'(cyc + 1 - mon_e.acc), LAT);
                check_eq("rdata", 32'(rdata), 32'(mon_e.rdata));
                check_eq("hold_m2", 32'(cpu_m2), 32'd0);
                check_eq("m2_clocks", 32'(m2_cnt), T_HI);
                check_eq("doe_clocks", 32'(doe_cnt), mon_e.rw ? 32'd0 : T_HI);
                m2_cnt  = 0;
                doe_cnt = 0;
            end
        end
    end

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cyc < target) check_eq("wait_timeout", 32'(cyc), 32'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic push_exp(input int acc, input logic rw, input logic [15:0] addr, input logic [7:0] wd);
        exp_t ent;
        if (rw) last_rd = din_fix_en ? din_fix : din_of(acc + int'(T_LO + T_HI) - 1);
        ent.acc = acc; ent.rw = rw; ent.addr = addr; ent.wdata = wd; ent.rdata = last_rd;
        sb.push_back(ent);
        model_addr = addr;
        last_acc = acc;
    endtask

    // acc_pred < 0: wait for idle and expect accept on the next edge
    task automatic issue(input logic rw, input logic [15:0] addr, input logic [7:0] wd, input int acc_pred);
        int acc;
        if (acc_pred < 0) begin
            wait_idle();
            acc = cyc + 1;
        end else begin
            acc = acc_pred;
        end
        req = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        push_exp(acc, rw, addr, wd);
        wait_cyc(acc);
        req = 1'b0; req_rw = ~rw; req_addr = 16'hFFFF; req_wdata = ~wd;
    endtask

    task automatic burst(input int n);
        int a0;
        wait_idle();
        a0 = cyc + 1;
        req = 1'b1; req_rw = 1'b1;
        for (int k = 0; k < n; k++) begin
            req_addr = (k % 2 == 0) ? 16'h8000 : 16'hC000;
            push_exp(a0 + k * int'(T_LO + T_HI + 2), 1'b1, req_addr, req_wdata);
            wait_cyc(a0 + k * int'(T_LO + T_HI + 2));
        end
        req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, 32'(ack), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_addr"}, 32'(cpu_addr), 32'd0);
        check_eq({tag, "_rw"}, 32'(cpu_rw), 32'd1);
        check_eq({tag, "_m2"}, 32'(cpu_m2), 32'd0);
        check_eq({tag, "_dout"}, 32'(cpu_dout), 32'd0);
        check_eq({tag, "_doe"}, 32'(cpu_doe), 32'd0);
        check_eq({tag, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Read with fixed bus data; address scrambled after accept
        din_fix_en = 1'b1;
        din_fix = 8'hA5;
        issue(1'b1, 16'h8000, 8'h00, -1);
        drain();
        check_eq("read_8000", 32'(rdata), 32'hA5);
        din_fix_en = 1'b0;

        issue(1'b0, 16'h6000, 8'h3C, -1);
        drain();
        check_eq("write_keeps_rdata", 32'(rdata), 32'hA5);

        burst(6);
        drain();

        for (int i = 0; i < 8; i++) begin
            issue(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), -1);
        end
        drain();

        // Reset on the second M2-high clock of a write
        issue(1'b0, 16'h6001, 8'h77, -1);
        wait_cyc(last_acc + int'(T_LO) + 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m2_cnt = 0;
        doe_cnt = 0;
        last_rd = '0;
        model_addr = '0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 16'h8002, 8'h00, cyc + 1);
        drain();

`ifdef CPU_BUS_MASTER_IDLE_CYCLE_EN
        begin
            int rise[$];
            logic prev_m2 = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cpu_m2 && !prev_m2) rise.push_back(cyc);
                prev_m2 = cpu_m2;
                if (busy) begin
                    check_eq("dummy_rw", 32'(cpu_rw), 32'd1);
                    check_eq("dummy_addr", 32'(cpu_addr), 32'(model_addr));
                end
            end
            check_eq("dummy_rises", 32'(rise.size() >= 3), 32'd1);
            for (int i = 1; i < rise.size(); i++) begin
                check_eq("m2_period", 32'(rise[i] - rise[i-1]), T_LO + T_HI + 2);
            end
            for (int i = 0; i < 20 && !(cpu_m2 && !prev_m2); i++) begin
                prev_m2 = cpu_m2;
                @(negedge clk);
            end
            check_eq("dummy_found", 32'(cpu_m2), 32'd1);
            issue(1'b1, 16'h4020, 8'h00, cyc + int'(T_HI) + 2);
            drain();
        end
`endif

        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
